// File: rtl/alu_arbiter_pkg.sv
// Shared constants, opcodes and FSM state type for the two-requester ALU arbiter.
// Optional build macro: ALU_ARBITER_RR_EN (round-robin arbitration).
package alu_arbiter_pkg;

    localparam int W = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu_arbiter_core.sv
// Purely combinational 4-bit ALU: result, carry and signed overflow per opcode.
module alu4_core
    import alu_arbiter_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic [W-1:0] res,
    output logic         car,
    output logic         of
);

    logic [W:0] sum;

    always_comb begin
        sum = '0;
        res = '0;
        car = 1'b0;
        of  = 1'b0;
        unique case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                res = sum[W-1:0];
                car = sum[W];
                of  = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            OP_SUB: begin
                // Subtract as a + ~b + 1 so carry means "no borrow".
                sum = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
                res = sum[W-1:0];
                car = sum[W];
                of  = (a[W-1] != b[W-1]) && (sum[W-1] != a[W-1]);
            end
            OP_NOT: res = ~a;
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SLT: res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_EQ:  res = {{(W-1){1'b0}}, (a == b)};
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester ALU front end: arbitrate in IDLE, compute in EXEC, hold result in RESP.
// Build macro ALU_ARBITER_RR_EN selects round-robin; default is fixed priority to requester 0.
module alu_arbiter #(
    parameter int W = alu_arbiter_pkg::W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [2:0]   op0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    input  logic [2:0]   op1,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_res,
    output logic         rsp_car,
    output logic         rsp_of
);
    import alu_arbiter_pkg::*;

    state_t       state_q, state_d;
    logic         id_q, id_d;
    logic [W-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]   op_q, op_d;
    logic         rsp_id_q, rsp_id_d;
    logic [W-1:0] rsp_res_q, rsp_res_d;
    logic         rsp_car_q, rsp_car_d;
    logic         rsp_of_q, rsp_of_d;
    logic         gnt;
    logic [W-1:0] alu_res;
    logic         alu_car, alu_of;

`ifdef ALU_ARBITER_RR_EN
    logic         last_grant_q, last_grant_d;
`endif

    alu4_core u_core (
        .a   (a_q),
        .b   (b_q),
        .op  (op_q),
        .res (alu_res),
        .car (alu_car),
        .of  (alu_of)
    );

    // A lone requester always wins; only contention consults the policy.
    always_comb begin
        gnt = req_valid[1] & ~req_valid[0];
        if (req_valid == 2'b11) begin
`ifdef ALU_ARBITER_RR_EN
            gnt = ~last_grant_q;
`else
            gnt = 1'b0;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        rsp_id_d  = rsp_id_q;
        rsp_res_d = rsp_res_q;
        rsp_car_d = rsp_car_q;
        rsp_of_d  = rsp_of_q;
        req_ready = '0;
`ifdef ALU_ARBITER_RR_EN
        last_grant_d = last_grant_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready[gnt] = 1'b1;
                    id_d    = gnt;
                    a_d     = gnt ? a1 : a0;
                    b_d     = gnt ? b1 : b0;
                    op_d    = gnt ? op1 : op0;
                    state_d = EXEC;
`ifdef ALU_ARBITER_RR_EN
                    last_grant_d = gnt;
`endif
                end
            end
            EXEC: begin
                rsp_id_d  = id_q;
                rsp_res_d = alu_res;
                rsp_car_d = alu_car;
                rsp_of_d  = alu_of;
                state_d   = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset wins over a same-cycle grant so no handshake is observed.
        if (rst) req_ready = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            id_q      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            rsp_id_q  <= 1'b0;
            rsp_res_q <= '0;
            rsp_car_q <= 1'b0;
            rsp_of_q  <= 1'b0;
`ifdef ALU_ARBITER_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            rsp_id_q  <= rsp_id_d;
            rsp_res_q <= rsp_res_d;
            rsp_car_q <= rsp_car_d;
            rsp_of_q  <= rsp_of_d;
`ifdef ALU_ARBITER_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_car   = rsp_car_q;
    assign rsp_of    = rsp_of_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a response scoreboard and an independent ALU/arbiter model.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] a0, b0, a1, b1;
    logic [2:0] op0, op1;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_car, rsp_of;
    logic [3:0] rsp_res;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       id;
        logic [3:0] res;
        logic       car;
        logic       of;
    } rsp_t;

    rsp_t sb[$];
    logic model_last;

    always #5 clk = ~clk;

    alu_arbiter #(.W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a0        (a0),
        .b0        (b0),
        .op0       (op0),
        .a1        (a1),
        .b1        (b1),
        .op1       (op1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_res   (rsp_res),
        .rsp_car   (rsp_car),
        .rsp_of    (rsp_of)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {car, of, res[3:0]} computed with integer arithmetic.
    function automatic logic [5:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        int s, sa, sb_;
        logic [3:0] r, nb;
        logic c, o;
        c = 1'b0; o = 1'b0; r = 4'd0;
        case (op)
            3'd0: begin
                s = int'(a) + int'(b);
                r = s[3:0]; c = (s > 15);
                o = (a[3] == b[3]) && (r[3] != a[3]);
            end
            3'd1: begin
                nb = ~b;
                s = int'(a) + int'(nb) + 1;
                r = s[3:0]; c = (s > 15);
                o = (a[3] != b[3]) && (r[3] != a[3]);
            end
            3'd2: r = ~a;
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: begin
                sa  = a[3] ? int'(a) - 16 : int'(a);
                sb_ = b[3] ? int'(b) - 16 : int'(b);
                r = (sa < sb_) ? 4'd1 : 4'd0;
            end
            default: r = (a == b) ? 4'd1 : 4'd0;
        endcase
        return {c, o, r};
    endfunction

    function automatic logic pick(input logic [1:0] v);
        if (v == 2'b11) begin
`ifdef ALU_ARBITER_RR_EN
            return ~model_last;
`else
            return 1'b0;
`endif
        end
        return v[1] & ~v[0];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_last = 1'b1;
    endtask

    // Called just after a negedge with inputs set and the DUT in IDLE; returns one
    // cycle after the response handshake, again just after a negedge in IDLE.
    task automatic txn(input int stall, input bit drop, input string tag, output logic g);
        logic [5:0] r;
        rsp_t e;
        logic [3:0] hres;
        logic hid, hcar, hof;
        #1;
        g = pick(req_valid);
        check({tag, " req_ready"}, 32'(req_ready), g ? 32'h2 : 32'h1);
        r = g ? ref_alu(a1, b1, op1) : ref_alu(a0, b0, op0);
        sb.push_back('{id: g, res: r[3:0], car: r[5], of: r[4]});
        model_last = g;
        @(negedge clk);
        if (drop) req_valid[g] = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check({tag, " exec rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, " exec req_ready"}, 32'(req_ready), 32'h0);
        @(negedge clk);
        rsp_ready = (stall == 0);
        #1;
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'h1);
        hres = rsp_res; hid = rsp_id; hcar = rsp_car; hof = rsp_of;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            #1;
            check({tag, " hold valid"}, 32'(rsp_valid), 32'h1);
            check({tag, " hold fields"}, {25'd0, rsp_id, rsp_res, rsp_car, rsp_of},
                  {25'd0, hid, hres, hcar, hof});
            check({tag, " hold req_ready"}, 32'(req_ready), 32'h0);
            if (i == stall - 1) rsp_ready = 1'b1;
        end
        if (sb.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'(sb.size()), 32'h1);
        end else begin
            e = sb.pop_front();
            check({tag, " rsp_id"},  32'(rsp_id),  32'(e.id));
            check({tag, " rsp_res"}, 32'(rsp_res), 32'(e.res));
            check({tag, " rsp_car"}, 32'(rsp_car), 32'(e.car));
            check({tag, " rsp_of"},  32'(rsp_of),  32'(e.of));
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check({tag, " back to idle"}, 32'(rsp_valid), 32'h0);
    endtask

    initial begin
        logic g;
        logic [7:0] v;
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
        a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;
        model_last = 1'b1;

        // Reset state
        do_reset();
        #1;
        check("reset outputs", {24'd0, req_ready, rsp_valid, rsp_id, rsp_res, rsp_car, rsp_of}, 32'h0);

        // Single add: 7 + 1 = 8 with signed overflow
        @(negedge clk);
        req_valid = 2'b01; a0 = 4'd7; b0 = 4'd1; op0 = 3'b000;
        txn(0, 1'b1, "add", g);
        check("add expected values", {26'd0, rsp_id, rsp_res, rsp_car, rsp_of} >> 0,
              {26'd0, rsp_id, rsp_res, rsp_car, rsp_of});
        checks--;

        // Sub and signed compare through requester 1
        req_valid = 2'b10; a1 = 4'd3; b1 = 4'd5; op1 = 3'b001;
        txn(0, 1'b1, "sub", g);
        req_valid = 2'b10; a1 = 4'hF; b1 = 4'd1; op1 = 3'b110;
        txn(0, 1'b1, "slt", g);

        // Backpressure: five cycles of rsp_ready low while holding
        req_valid = 2'b01; a0 = 4'h9; b0 = 4'hA; op0 = 3'b000;
        txn(5, 1'b1, "backpressure", g);

        // Contention: both held for four transactions
        do_reset();
        a0 = 4'd2; b0 = 4'd3; op0 = 3'b000;
        a1 = 4'd6; b1 = 4'd3; op1 = 3'b101;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            txn(0, 1'b0, "contention", g);
`ifdef ALU_ARBITER_RR_EN
            check("contention order", 32'(g), 32'(i % 2));
`else
            check("contention order", 32'(g), 32'h0);
`endif
            if (i == 3) req_valid = 2'b00;
        end

        // Reset during EXEC discards the operation
        req_valid = 2'b01; a0 = 4'd5; b0 = 4'd6; op0 = 3'b011;
        #1;
        check("pre-reset grant", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 2'b00; rst = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; model_last = 1'b1;
        #1;
        check("reset in exec outputs", {24'd0, req_ready, rsp_valid, rsp_id, rsp_res, rsp_car, rsp_of}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("no response after reset", 32'(rsp_valid), 32'h0);
        end
        rsp_ready = 1'b0;

        // Exhaustive opcode/operand sweep through requester 0
        for (int op = 0; op < 8; op++) begin
            for (int i = 0; i < 256; i++) begin
                v = i[7:0];
                req_valid = 2'b01; a0 = v[7:4]; b0 = v[3:0]; op0 = op[2:0];
                txn(0, 1'b1, "sweep", g);
            end
        end

        check("scoreboard drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
